rs485_dir_ctrl: RTL

Direction controller for a half-duplex RS-485/RS-422 transceiver buffer. It sits between a UART and the serial buffer's `in_DI`/`in_DE`/`in_RE`/`out_RO` pins. It sequences driver-enable lead and tail guard times around each UART transmission and grants the UART permission to shift. It also suppresses local echo on the receive path while the line is driven.

---
 rtl/rs485_pkg.sv | 5 +
 rtl/sync_2ff.sv | 21 ++
 rtl/rs485_dir_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/rs485_pkg.sv
// rs485_pkg: state encoding and counter width shared by the RS-485 direction controller.
package rs485_pkg;
  localparam int RS485_CNT_W = 16;
  typedef enum logic [1:0] {RX = 2'd0, LEAD = 2'd1, TX = 2'd2, TAIL = 2'd3} state_t;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer with async active-high reset to RST_VAL.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta_q, sync_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end
  assign q = sync_q;
endmodule

// File: rtl/rs485_dir_ctrl.sv
// rs485_dir_ctrl: half-duplex RS-485 driver-enable sequencing with lead/tail guard times and echo masking.
module rs485_dir_ctrl
  import rs485_pkg::*;
#(
  parameter int LEAD_CYCLES = 16,
  parameter int TAIL_CYCLES = 16,
  parameter int ECHO        = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic tx_req,
  output logic tx_grant,
  input  logic tx_busy,
  input  logic txd,
  output logic rxd,
  output logic dir_tx,
  output logic DI,
  output logic DE,
  output logic RE,
  input  logic RO
);
  localparam logic [RS485_CNT_W-1:0] LEAD_LOAD = RS485_CNT_W'(LEAD_CYCLES - 1);
  localparam logic [RS485_CNT_W-1:0] TAIL_LOAD = RS485_CNT_W'(TAIL_CYCLES - 1);
  localparam logic [RS485_CNT_W-1:0] CNT_ONE   = RS485_CNT_W'(1);
  localparam logic NO_ECHO = (ECHO == 0);
  state_t state_q, state_d;
  logic [RS485_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0] hold_q, hold_d;
  logic de_q, de_d, re_q, re_d, di_q, di_d, grant_q, grant_d, rxd_q, rxd_d;
  logic ro_s;
  sync_2ff #(.RST_VAL(1'b1)) u_ro_sync (.clk(clk), .rst(rst), .d(RO), .q(ro_s));
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RX:   if (tx_req) begin
              state_d = LEAD;
              cnt_d   = LEAD_LOAD;
            end
      LEAD: if (cnt_q == '0) state_d = TX;
            else cnt_d = cnt_q - CNT_ONE;
      TX:   if (!tx_busy && !tx_req) begin
              state_d = TAIL;
              cnt_d   = TAIL_LOAD;
            end
      TAIL: if (tx_req) state_d = TX;
            else if (cnt_q == '0) state_d = RX;
            else cnt_d = cnt_q - CNT_ONE;
    endcase
    de_d    = state_d != RX;
    re_d    = NO_ECHO && de_d;
    grant_d = state_d == TX;
    di_d    = (state_d == TX || state_d == TAIL) ? txd : 1'b1;
    // Keep masking two clocks past RX entry so echo still in the synchronizer is dropped.
    hold_d  = (state_q != RX) ? 2'd2 : (hold_q != 2'd0) ? hold_q - 2'd1 : 2'd0;
    rxd_d   = (NO_ECHO && (state_q != RX || hold_q != 2'd0)) ? 1'b1 : ro_s;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RX;
      cnt_q   <= '0;
      hold_q  <= 2'd0;
      de_q    <= 1'b0;
      re_q    <= 1'b0;
      di_q    <= 1'b1;
      grant_q <= 1'b0;
      rxd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
      de_q    <= de_d;
      re_q    <= re_d;
      di_q    <= di_d;
      grant_q <= grant_d;
      rxd_q   <= rxd_d;
    end
  end
  assign tx_grant = grant_q;
  assign rxd      = rxd_q;
  assign dir_tx   = de_q;
  assign DI       = di_q;
  assign DE       = de_q;
  assign RE       = re_q;
endmodule
